// File: rtl/fetch_unit.sv
// Instruction fetch front end: owns the program counter, fetches words from
// instruction memory over a req/ack handshake, buffers them in a two-entry
// queue and applies branch/jump redirects from the control block.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] Instr,
  output logic [31:0] PC,
  output logic [31:0] PCPlus4,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        PCsrc,
  input  logic        reg_jump,
  input  logic [31:0] ImmExt,
  input  logic [31:0] ALUResult,
  output logic        fetch_fault
);

  logic [31:0] fetch_pc_reg;
  logic [31:0] q_instr_reg [2];
  logic [31:0] q_pc_reg    [2];
  logic        rd_ptr_reg;
  logic        wr_ptr_reg;
  logic [1:0]  count_reg;
  logic        fault_reg;

  logic        pop;
  logic        redirect;
  logic        push;
  logic [31:0] target;

  // Request depends only on registered occupancy (and reset), never on the
  // consumer's ready, so there is no combinational path through the queue.
  assign imem_req    = (count_reg != 2'd2) && !rst;
  assign imem_addr   = fetch_pc_reg;
  assign instr_valid = (count_reg != 2'd0);
  assign fetch_fault = fault_reg;

  assign Instr   = instr_valid ? q_instr_reg[rd_ptr_reg] : NOP_INSTR;
  assign PC      = instr_valid ? q_pc_reg[rd_ptr_reg]    : 32'h0000_0000;
  assign PCPlus4 = PC + 32'd4;

  assign pop      = instr_valid && instr_ready;
  assign redirect = pop && PCsrc;
  // A redirect discards whatever memory returns in the same cycle.
  assign push     = imem_req && imem_ack && !redirect;
  assign target   = reg_jump ? ALUResult : (PC + ImmExt);

  // Queue storage: each slot captures the returned word and its address
  // when the write pointer selects it. Contents need no reset because
  // occupancy alone decides whether they are visible.
  for (genvar gi = 0; gi < 2; gi++) begin : g_slot
    localparam logic SLOT = 1'(gi);
    always_ff @(posedge clk) begin
      if (push && (wr_ptr_reg == SLOT)) begin
        q_instr_reg[gi] <= imem_rdata;
        q_pc_reg[gi]    <= fetch_pc_reg;
      end
    end
  end

  // Program counter, queue pointers/occupancy and the sticky fault flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_reg <= RESET_PC;
      rd_ptr_reg   <= 1'b0;
      wr_ptr_reg   <= 1'b0;
      count_reg    <= 2'd0;
      fault_reg    <= 1'b0;
    end else if (redirect) begin
      fetch_pc_reg <= {target[31:2], 2'b00};
      rd_ptr_reg   <= 1'b0;
      wr_ptr_reg   <= 1'b0;
      count_reg    <= 2'd0;
      if (target[1:0] != 2'b00) begin
        fault_reg <= 1'b1;
      end
    end else begin
      if (push) begin
        fetch_pc_reg <= fetch_pc_reg + 32'd4;
        wr_ptr_reg   <= ~wr_ptr_reg;
      end
      if (pop) begin
        rd_ptr_reg <= ~rd_ptr_reg;
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 2'd1;
        2'b01:   count_reg <= count_reg - 2'd1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a queue-based reference model predicts the
// outputs every cycle, and literal expectations pin key test-plan points.
module tb_fetch_unit;
  localparam logic [31:0] RST_PC = 32'h0000_0100;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic [31:0] Instr;
  logic [31:0] PC;
  logic [31:0] PCPlus4;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic        PCsrc = 1'b0;
  logic        reg_jump = 1'b0;
  logic [31:0] ImmExt = 32'h0;
  logic [31:0] ALUResult = 32'h0;
  logic        fetch_fault;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(RST_PC), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .Instr(Instr), .PC(PC), .PCPlus4(PCPlus4),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .PCsrc(PCsrc), .reg_jump(reg_jump), .ImmExt(ImmExt),
    .ALUResult(ALUResult), .fetch_fault(fetch_fault)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: queue of {instr, pc}, next fetch address, fault flag.
  logic [63:0] m_q[$];
  logic [31:0] m_fpc;
  logic        m_fault;
  bit          model_ok = 0;

  // Outputs sampled in the most recent step (for literal checks).
  logic        s_req, s_valid, s_fault;
  logic [31:0] s_addr, s_instr, s_pc, s_pc4;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h0F0F_0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%08h required=%08h", name, act, exp);
    end
  endtask

  // One clock cycle: drive inputs, compare against the model, then advance it.
  task automatic step(input bit r, input bit ack, input bit rdy, input bit src,
                      input bit rj, input logic [31:0] imm, input logic [31:0] alu);
    bit          e_req, e_valid, do_push, do_pop, do_redir;
    logic [31:0] e_instr, e_pc, tgt;
    @(negedge clk);
    rst = r; imem_ack = ack; instr_ready = rdy; PCsrc = src; reg_jump = rj;
    ImmExt = imm; ALUResult = alu; imem_rdata = mem_word(m_fpc);
    #1;
    s_req = imem_req; s_addr = imem_addr; s_instr = Instr; s_pc = PC;
    s_pc4 = PCPlus4; s_valid = instr_valid; s_fault = fetch_fault;
    e_req   = (m_q.size() < 2) && !r;
    e_valid = (m_q.size() > 0);
    e_instr = e_valid ? m_q[0][63:32] : NOP;
    e_pc    = e_valid ? m_q[0][31:0]  : 32'h0;
    if (model_ok) begin
      chk("imem_req", 32'(s_req), 32'(e_req));
      if (e_req) chk("imem_addr", s_addr, m_fpc);
      chk("instr_valid", 32'(s_valid), 32'(e_valid));
      chk("Instr", s_instr, e_instr);
      chk("PC", s_pc, e_pc);
      chk("PCPlus4", s_pc4, e_pc + 32'd4);
      chk("fetch_fault", 32'(s_fault), 32'(m_fault));
    end
    @(posedge clk);
    if (r) begin
      m_q.delete();
      m_fpc    = RST_PC;
      m_fault  = 1'b0;
      model_ok = 1;
    end else begin
      do_push  = e_req && ack;
      do_pop   = e_valid && rdy;
      do_redir = do_pop && src;
      if (do_redir) begin
        tgt = rj ? alu : (e_pc + imm);
        if (tgt[1:0] != 2'b00) m_fault = 1'b1;
        m_fpc = {tgt[31:2], 2'b00};
        m_q.delete();
      end else begin
        if (do_pop) void'(m_q.pop_front());
        if (do_push) begin
          m_q.push_back({mem_word(m_fpc), m_fpc});
          m_fpc = m_fpc + 32'd4;
        end
      end
    end
  endtask

  initial begin
    // Reset, with an ack offered during reset that must be ignored.
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0, 0);
    chk("rst_req", 32'(s_req), 32'd0);
    chk("rst_valid", 32'(s_valid), 32'd0);
    chk("rst_instr", s_instr, 32'h0000_0013);
    chk("rst_pc", s_pc, 32'h0);
    chk("rst_pc4", s_pc4, 32'h4);

    // Stream with ack and ready every cycle.
    step(0, 1, 1, 0, 0, 0, 0);
    chk("first_req", 32'(s_req), 32'd1);
    chk("first_addr", s_addr, 32'h0000_0100);
    chk("first_valid", 32'(s_valid), 32'd0);
    step(0, 1, 1, 0, 0, 0, 0);
    chk("stream_valid", 32'(s_valid), 32'd1);
    chk("stream_pc0", s_pc, 32'h0000_0100);
    chk("stream_instr0", s_instr, 32'h0E0F_FEFF);
    step(0, 1, 1, 0, 0, 0, 0);
    chk("stream_pc1", s_pc, 32'h0000_0104);
    repeat (3) step(0, 1, 1, 0, 0, 0, 0);

    // Backpressure: queue fills, request drops, reasserts after a pop.
    repeat (5) step(0, 1, 0, 0, 0, 0, 0);
    chk("bp_full_req", 32'(s_req), 32'd0);
    step(0, 0, 1, 0, 0, 0, 0);
    chk("bp_pop_req", 32'(s_req), 32'd0);
    step(0, 0, 1, 0, 0, 0, 0);
    chk("bp_rearm_req", 32'(s_req), 32'd1);
    repeat (3) step(0, 1, 1, 0, 0, 0, 0);

    // Jump to 0x200, then branch back by 16 with a same-cycle ack.
    step(0, 1, 1, 1, 1, 0, 32'h0000_0200);
    step(0, 1, 0, 0, 0, 0, 0);
    chk("jmp_addr", s_addr, 32'h0000_0200);
    step(0, 1, 1, 1, 0, 32'hFFFF_FFF0, 0);
    chk("br_head_pc", s_pc, 32'h0000_0200);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("br_addr", s_addr, 32'h0000_01F0);
    chk("br_flushed", 32'(s_valid), 32'd0);

    // Misaligned JALR target sets the sticky fault.
    step(0, 1, 0, 0, 0, 0, 0);
    step(0, 0, 1, 1, 1, 0, 32'h0000_0403);
    chk("jalr_fault_before", 32'(s_fault), 32'd0);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("jalr_addr", s_addr, 32'h0000_0400);
    chk("jalr_fault", 32'(s_fault), 32'd1);
    repeat (4) step(0, 1, 1, 0, 0, 0, 0);
    chk("fault_sticky", 32'(s_fault), 32'd1);

    // Address wrap around the top of memory.
    step(0, 1, 1, 1, 1, 0, 32'hFFFF_FFF8);
    step(0, 1, 1, 0, 0, 0, 0);
    chk("wrap_addr0", s_addr, 32'hFFFF_FFF8);
    step(0, 1, 1, 0, 0, 0, 0);
    chk("wrap_addr1", s_addr, 32'hFFFF_FFFC);
    step(0, 1, 1, 0, 0, 0, 0);
    chk("wrap_pc", s_pc, 32'hFFFF_FFFC);
    chk("wrap_pc4", s_pc4, 32'h0);
    chk("wrap_addr2", s_addr, 32'h0);
    step(0, 1, 1, 0, 0, 0, 0);
    chk("wrap_head0", s_pc, 32'h0);

    // Mid-stream reset with a full queue and an ack in the reset cycle.
    repeat (3) step(0, 1, 0, 0, 0, 0, 0);
    chk("pre_rst_req", 32'(s_req), 32'd0);
    step(1, 1, 0, 0, 0, 0, 0);
    // PCsrc with an empty queue has no effect.
    step(0, 0, 1, 1, 0, 32'h4, 0);
    chk("mrst_valid", 32'(s_valid), 32'd0);
    chk("mrst_instr", s_instr, 32'h0000_0013);
    chk("mrst_addr", s_addr, 32'h0000_0100);
    chk("mrst_fault", 32'(s_fault), 32'd0);
    repeat (2) step(0, 1, 1, 0, 0, 0, 0);
    chk("mrst_head", s_pc, 32'h0000_0100);
    step(0, 1, 1, 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
